alu_result_stage: RTL and testbench
===================================

Name: alu_result_stage

Overview:
- Downstream stage of the 4-bit ALU. Captures ALU_Out, Error and the issuing Opcode into a 2-entry result buffer with a valid/ready handshake.
- Derives per-result Z/V/N flags and commits them to the architectural flag register when each result is consumed by writeback.
- Keeps a sticky overflow indicator and a saturating overflow counter for debug.

Parameters:
- WIDTH, 4, data width of ALU results
- CNT_W, 8, width of the saturating overflow counter

Ports:
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  ALU result present this cycle
- in_ready  output  1  stage can accept a result
- alu_out  input  WIDTH  result from the ALU
- alu_err  input  1  ALU Error (overflow) for this result
- opcode  input  2  opcode that produced the result
- out_valid  output  1  head entry is valid
- out_ready  input  1  writeback consumes the head entry
- out_data  output  WIDTH  head entry result
- out_flags  output  3  head entry flags {Z,V,N}
- flag_reg  output  3  architectural flags {Z,V,N}
- ovfl_sticky  output  1  at least one overflowed result has been committed since the last clear
- clr_sticky  input  1  clears ovfl_sticky
- ovfl_count  output  CNT_W  number of committed overflowed results, saturating

Behaviour:
- Reset and clock: single clock clk; rst is asynchronous and active-high. On reset:
  - buffer is emptied and both pointers are 0
  - out_valid=0, out_data=0, out_flags=0
  - flag_reg=3'b000, ovfl_sticky=0, ovfl_count=0
  - in_ready=1 on the first cycle after reset deasserts
- Reset mid-operation discards all buffered entries; nothing is committed.
- Buffer: 2 entries, each holding {data, Z, V, N, opcode}.
  - Occupancy states: EMPTY, ONE, FULL.
  - in_ready = (state != FULL).
  - Push when in_valid && in_ready. Pop when out_valid && out_ready.
- State transitions:
  - EMPTY + push -> ONE.
  - ONE + push only -> FULL. ONE + pop only -> EMPTY. ONE + push + pop -> ONE (both pointers advance).
  - FULL + pop -> ONE. Push is impossible in FULL because in_ready=0; there is no same-cycle pass-through.
- Latency: a result pushed in cycle t is presented with out_valid=1 in cycle t+1 (registered output, no combinational in->out path).
- Order: entries leave in push order. Pointers are 1 bit and wrap naturally.
- Flag derivation at push:
  - Z = (alu_out == 0)
  - N = alu_out[WIDTH-1]
  - V = alu_err when opcode is ADD(00) or SUB(01), else 0
- Empty output: out_data and out_flags drive 0 while out_valid=0.
- Commit on pop (flag_reg updated on the same clock edge as the pop):
  - ADD/SUB: flag_reg <= {Z,V,N} of the entry
  - NAND/XOR: flag_reg.Z <= entry Z; V and N hold their values
- Overflow tracking on pop of an entry with V=1:
  - ovfl_count increments; it saturates at 2^CNT_W-1 and never wraps
  - ovfl_sticky <= 1
- Sticky clear:
  - clr_sticky=1 clears ovfl_sticky on the next edge.
  - If a clear and a V=1 pop occur in the same cycle, the set wins.
  - clr_sticky does not affect ovfl_count.
- in_valid while in_ready=0: input is ignored; the upstream must hold it.
- out_data and out_flags stay stable while out_valid=1 && out_ready=0.

Decomposition:
- Shared package alu_pkg:
  - opcode enum OP_ADD=2'b00, OP_SUB=2'b01, OP_NAND=2'b10, OP_XOR=2'b11
  - flag index constants FLAG_Z=2, FLAG_V=1, FLAG_N=0
  - packed struct alu_result_t {data, z, v, n, op}
- One natural sub-module: alu_result_fifo, the 2-entry storage with pointers, occupancy and handshake.
- Flag derivation, commit logic and the overflow counter live in alu_result_stage.

Test Plan:
- Reset mid-stream: push 2 entries, assert rst asynchronously between edges -> out_valid=0, flag_reg=000, ovfl_count=0 immediately, in_ready=1 after release.
- Single ADD: alu_out=4'h0, alu_err=0, opcode=00, out_ready=1 -> out_valid next cycle with out_flags=100; flag_reg=100 after pop.
- Overflow SUB: alu_out=4'h8, alu_err=1, opcode=01 -> out_flags=011; after pop flag_reg=011, ovfl_sticky=1, ovfl_count=1.
- Backpressure: out_ready=0, push 4'h3, 4'h5 -> in_ready=0 after the second push, third input ignored. Then out_ready=1 -> pops 3 then 5 in order, in_ready returns to 1.
- Logic op after overflow: flag_reg=011, then XOR result 4'h0 with alu_err=1 -> entry V=0; flag_reg becomes 111 (Z set, V and N held).
- Sticky and saturation: clr_sticky coincident with a V=1 pop -> ovfl_sticky stays 1. With CNT_W=2, 5 overflowed pops -> ovfl_count=3.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared definitions for the 4-bit ALU result path.
//   opcode_e      : ALU opcode encoding
//   FLAG_*        : bit positions of {Z,V,N} in 3-bit flag vectors
//   alu_result_t  : one buffered result at the default ALU width
//   is_arith      : true for opcodes whose Error output means overflow
package alu_pkg;

  localparam int ALU_W = 4;

  typedef enum logic [1:0] {
    OP_ADD  = 2'b00,
    OP_SUB  = 2'b01,
    OP_NAND = 2'b10,
    OP_XOR  = 2'b11
  } opcode_e;

  localparam int FLAG_Z = 2;
  localparam int FLAG_V = 1;
  localparam int FLAG_N = 0;

  typedef struct packed {
    logic [ALU_W-1:0] data;
    logic             z;
    logic             v;
    logic             n;
    opcode_e          op;
  } alu_result_t;

  function automatic logic is_arith(opcode_e op);
    return (op == OP_ADD) || (op == OP_SUB);
  endfunction

endpackage

// File: rtl/alu_result_fifo.sv
// Two-entry in-order result buffer with a valid/ready handshake on both sides.
//   clk, rst             : clock, asynchronous active-high reset
//   in_valid/in_ready    : producer handshake; in_ready is low only when full
//   in_entry             : entry written on push
//   out_valid/out_ready  : consumer handshake; out_valid is high when not empty
//   out_entry            : head entry, all zeros while empty
// Output is taken from storage only, so a push is first visible one cycle later.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter type entry_t = alu_result_t
) (
  input  logic   clk,
  input  logic   rst,
  input  logic   in_valid,
  output logic   in_ready,
  input  entry_t in_entry,
  output logic   out_valid,
  input  logic   out_ready,
  output entry_t out_entry
);

  localparam logic [1:0] EMPTY = 2'd0;
  localparam logic [1:0] ONE   = 2'd1;
  localparam logic [1:0] FULL  = 2'd2;

  logic [1:0] state, state_nxt;
  logic       wr_ptr, rd_ptr;
  logic       push, pop;
  entry_t     mem [2];

  assign in_ready  = (state != FULL);
  assign out_valid = (state != EMPTY);
  assign push      = in_valid && in_ready;
  assign pop       = out_valid && out_ready;
  assign out_entry = out_valid ? mem[rd_ptr] : '0;

  always_comb begin
    // NOTE: default first so every path assigns state_nxt and no latch is inferred.
    state_nxt = state;
    unique case (state)
      EMPTY:   if (push) state_nxt = ONE;
      ONE: begin
        if (push && !pop)      state_nxt = FULL;
        else if (pop && !push) state_nxt = EMPTY;
      end
      FULL:    if (pop) state_nxt = ONE;
      default: state_nxt = EMPTY;
    endcase
  end

  // NOTE: non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= EMPTY;
      wr_ptr <= 1'b0;
      rd_ptr <= 1'b0;
    end else begin
      state <= state_nxt;
      if (push) wr_ptr <= ~wr_ptr;
      if (pop)  rd_ptr <= ~rd_ptr;
    end
  end

  // NOTE: storage is not reset; stale contents are never observable because
  // out_entry is forced to zero whenever the buffer is empty.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= in_entry;
  end

endmodule

// File: rtl/alu_result_stage.sv
// ALU result stage: buffers results, derives {Z,V,N}, commits flags on writeback.
//   clk, rst              : clock, asynchronous active-high reset
//   in_valid/in_ready     : ALU-side handshake
//   alu_out/alu_err/opcode: result, Error and issuing opcode
//   out_valid/out_ready   : writeback handshake
//   out_data/out_flags    : head entry result and its {Z,V,N} (zero when empty)
//   flag_reg              : architectural {Z,V,N}, updated when an entry is popped
//   ovfl_sticky/clr_sticky: sticky overflow indicator and its clear
//   ovfl_count            : saturating count of committed overflowed results
module alu_result_stage
  import alu_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] alu_out,
  input  logic             alu_err,
  input  logic [1:0]       opcode,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [2:0]       out_flags,
  output logic [2:0]       flag_reg,
  output logic             ovfl_sticky,
  input  logic             clr_sticky,
  output logic [CNT_W-1:0] ovfl_count
);

  // Same layout as alu_result_t but following this instance's WIDTH.
  typedef struct packed {
    logic [WIDTH-1:0] data;
    logic             z;
    logic             v;
    logic             n;
    opcode_e          op;
  } entry_t;

  entry_t  in_entry, head;
  opcode_e in_op;
  logic    pop, pop_ovfl;

  assign in_op         = opcode_e'(opcode);
  assign in_entry.data = alu_out;
  assign in_entry.z    = (alu_out == '0);
  assign in_entry.n    = alu_out[WIDTH-1];
  // Error means overflow only for arithmetic; logic ops never set V.
  assign in_entry.v    = alu_err && is_arith(in_op);
  assign in_entry.op   = in_op;

  alu_result_fifo #(.entry_t(entry_t)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_entry  (in_entry),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_entry (head)
  );

  assign out_data  = head.data;
  assign out_flags = {head.z, head.v, head.n};
  assign pop       = out_valid && out_ready;
  assign pop_ovfl  = pop && head.v;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      flag_reg    <= 3'b000;
      ovfl_sticky <= 1'b0;
      ovfl_count  <= '0;
    end else begin
      if (pop) begin
        if (is_arith(head.op)) flag_reg <= {head.z, head.v, head.n};
        else                   flag_reg[FLAG_Z] <= head.z;
      end
      // A coincident overflow commit takes priority over the clear.
      if (pop_ovfl)        ovfl_sticky <= 1'b1;
      else if (clr_sticky) ovfl_sticky <= 1'b0;
      if (pop_ovfl && (ovfl_count != '1)) ovfl_count <= ovfl_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_alu_result_stage.sv
module tb_alu_result_stage;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [3:0] alu_out = 4'h0;
  logic       alu_err = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [3:0] out_data;
  logic [2:0] out_flags;
  logic [2:0] flag_reg;
  logic       ovfl_sticky;
  logic       clr_sticky = 1'b0;
  logic [1:0] ovfl_count;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  alu_result_stage #(.WIDTH(4), .CNT_W(2)) dut (
    .clk         (clk),
    .rst         (rst),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .alu_out     (alu_out),
    .alu_err     (alu_err),
    .opcode      (opcode),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_data    (out_data),
    .out_flags   (out_flags),
    .flag_reg    (flag_reg),
    .ovfl_sticky (ovfl_sticky),
    .clr_sticky  (clr_sticky),
    .ovfl_count  (ovfl_count)
  );

  // Reference model: a plain queue of raw ALU results plus architectural state.
  typedef struct {
    logic [3:0] data;
    logic [1:0] op;
    logic       err;
  } ref_t;

  ref_t       mq[$];
  logic [2:0] m_flag   = 3'b000;
  logic       m_sticky = 1'b0;
  int         m_count  = 0;

  function automatic logic [2:0] ref_flags(ref_t e);
    logic z, v, n;
    z = (e.data == 4'd0);
    n = (e.data >= 4'd8);
    v = e.err && (e.op <= 2'd1);
    return {z, v, n};
  endfunction

  function automatic void model_reset();
    mq.delete();
    m_flag   = 3'b000;
    m_sticky = 1'b0;
    m_count  = 0;
  endfunction

  // Advance one clock; inputs are held across the edge, model updated after it.
  task automatic tick();
    bit         push, pop, ovf;
    ref_t       h, n;
    logic [2:0] f;
    push = in_valid && (mq.size() < 2);
    pop  = out_ready && (mq.size() > 0);
    n.data = alu_out; n.op = opcode; n.err = alu_err;
    @(posedge clk);
    #1;
    ovf = 1'b0;
    if (pop) begin
      h = mq.pop_front();
      f = ref_flags(h);
      if (h.op <= 2'd1) m_flag = f;
      else              m_flag[2] = f[2];
      ovf = f[1];
    end
    if (ovf) begin
      m_sticky = 1'b1;
      if (m_count < 3) m_count++;
    end else if (clr_sticky) begin
      m_sticky = 1'b0;
    end
    if (push) mq.push_back(n);
  endtask

  task automatic drive(input logic v, input logic [3:0] d, input logic e, input logic [1:0] op);
    in_valid = v; alu_out = d; alu_err = e; opcode = op;
  endtask

  task automatic test_reset();
    #12;
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
    total++; if ({out_data, out_flags} !== 7'd0) begin bad++; $display("FAIL reset_out_data_flags got=%h/%b exp=0/000", out_data, out_flags); end
    total++; if (flag_reg !== 3'b000 || ovfl_sticky !== 1'b0 || ovfl_count !== 2'd0) begin
      bad++; $display("FAIL reset_arch got flag=%b sticky=%b cnt=%0d exp 000/0/0", flag_reg, ovfl_sticky, ovfl_count);
    end
    @(negedge clk); rst = 1'b0;
    @(posedge clk); #1;
    model_reset();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
  endtask

  task automatic test_single_add();
    out_ready = 1'b1;
    drive(1'b1, 4'h0, 1'b0, 2'b00);
    tick();
    drive(1'b0, 4'h0, 1'b0, 2'b00);
    total++; if (out_valid !== 1'b1 || out_flags !== 3'b100 || out_data !== 4'h0) begin
      bad++; $display("FAIL add_head got v=%b d=%h f=%b exp 1/0/100", out_valid, out_data, out_flags);
    end
    tick();
    total++; if (flag_reg !== 3'b100) begin bad++; $display("FAIL add_commit got=%b exp=100", flag_reg); end
    total++; if (out_valid !== 1'b0 || out_flags !== 3'b000) begin
      bad++; $display("FAIL add_empty got v=%b f=%b exp 0/000", out_valid, out_flags);
    end
  endtask

  task automatic test_overflow_sub();
    drive(1'b1, 4'h8, 1'b1, 2'b01);
    tick();
    drive(1'b0, 4'h0, 1'b0, 2'b00);
    total++; if (out_flags !== 3'b011) begin bad++; $display("FAIL sub_head_flags got=%b exp=011", out_flags); end
    tick();
    total++; if (flag_reg !== 3'b011 || ovfl_sticky !== 1'b1 || ovfl_count !== 2'd1) begin
      bad++; $display("FAIL sub_commit got flag=%b sticky=%b cnt=%0d exp 011/1/1", flag_reg, ovfl_sticky, ovfl_count);
    end
  endtask

  task automatic test_backpressure();
    out_ready = 1'b0;
    drive(1'b1, 4'h3, 1'b0, 2'b00); tick();
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL bp_ready_one got=%b exp=1", in_ready); end
    drive(1'b1, 4'h5, 1'b0, 2'b00); tick();
    total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_full got=%b exp=0", in_ready); end
    drive(1'b1, 4'h9, 1'b0, 2'b00); tick();
    total++; if (out_data !== 4'h3 || in_ready !== 1'b0) begin
      bad++; $display("FAIL bp_hold got d=%h rdy=%b exp 3/0", out_data, in_ready);
    end
    drive(1'b0, 4'h0, 1'b0, 2'b00);
    out_ready = 1'b1;
    tick();
    total++; if (out_data !== 4'h5 || in_ready !== 1'b1) begin
      bad++; $display("FAIL bp_second got d=%h rdy=%b exp 5/1", out_data, in_ready);
    end
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL bp_drained got=%b exp=0 (third input leaked)", out_valid); end
  endtask

  task automatic test_logic_after_ovfl();
    drive(1'b1, 4'h8, 1'b1, 2'b01); tick();
    drive(1'b1, 4'h0, 1'b1, 2'b11); tick();
    drive(1'b0, 4'h0, 1'b0, 2'b00);
    total++; if (flag_reg !== 3'b011 || out_flags !== 3'b100) begin
      bad++; $display("FAIL xor_setup got flag=%b head=%b exp 011/100", flag_reg, out_flags);
    end
    tick();
    total++; if (flag_reg !== 3'b111) begin bad++; $display("FAIL xor_commit got=%b exp=111", flag_reg); end
  endtask

  task automatic test_sticky_sat();
    // Overflows so far: 2. Clear coincident with the third.
    drive(1'b1, 4'hC, 1'b1, 2'b00); tick();
    drive(1'b0, 4'h0, 1'b0, 2'b00);
    clr_sticky = 1'b1; tick();
    total++; if (ovfl_sticky !== 1'b1 || ovfl_count !== 2'd3) begin
      bad++; $display("FAIL sticky_set_wins got sticky=%b cnt=%0d exp 1/3", ovfl_sticky, ovfl_count);
    end
    tick();
    clr_sticky = 1'b0;
    total++; if (ovfl_sticky !== 1'b0 || ovfl_count !== 2'd3) begin
      bad++; $display("FAIL sticky_clear got sticky=%b cnt=%0d exp 0/3", ovfl_sticky, ovfl_count);
    end
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 4'h9, 1'b1, 2'b01); tick();
    end
    drive(1'b0, 4'h0, 1'b0, 2'b00); tick();
    total++; if (ovfl_count !== 2'd3 || ovfl_sticky !== 1'b1) begin
      bad++; $display("FAIL count_saturate got cnt=%0d sticky=%b exp 3/1", ovfl_count, ovfl_sticky);
    end
  endtask

  task automatic test_reset_midstream();
    out_ready = 1'b0;
    drive(1'b1, 4'h6, 1'b0, 2'b00); tick();
    drive(1'b1, 4'h7, 1'b0, 2'b00); tick();
    drive(1'b0, 4'h0, 1'b0, 2'b00);
    #2 rst = 1'b1;
    #1;
    total++; if (out_valid !== 1'b0 || flag_reg !== 3'b000 || ovfl_count !== 2'd0 || ovfl_sticky !== 1'b0) begin
      bad++; $display("FAIL midreset_async got v=%b flag=%b cnt=%0d sticky=%b exp 0/000/0/0",
                      out_valid, flag_reg, ovfl_count, ovfl_sticky);
    end
    model_reset();
    @(negedge clk); rst = 1'b0;
    #1;
    total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL midreset_ready got=%b exp=1", in_ready); end
    out_ready = 1'b1;
    tick();
    total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL midreset_discard got=%b exp=0", out_valid); end
  endtask

  task automatic test_random();
    ref_t       h;
    logic [3:0] e_data;
    logic [2:0] e_flags;
    for (int c = 0; c < 400; c++) begin
      in_valid   = ($urandom_range(0, 3) != 0);
      alu_out    = 4'($urandom_range(0, 15));
      alu_err    = ($urandom_range(0, 2) == 0);
      opcode     = 2'($urandom_range(0, 3));
      out_ready  = ($urandom_range(0, 2) != 0);
      clr_sticky = ($urandom_range(0, 7) == 0);
      tick();
      if (mq.size() > 0) begin
        h = mq[0];
        e_data  = h.data;
        e_flags = ref_flags(h);
      end else begin
        e_data  = 4'h0;
        e_flags = 3'b000;
      end
      total++; if (out_valid !== (mq.size() > 0) || in_ready !== (mq.size() < 2)) begin
        bad++; $display("FAIL rnd_hs cyc=%0d got v=%b r=%b exp occ=%0d", c, out_valid, in_ready, mq.size());
      end
      total++; if (out_data !== e_data || out_flags !== e_flags) begin
        bad++; $display("FAIL rnd_head cyc=%0d got %h/%b exp %h/%b", c, out_data, out_flags, e_data, e_flags);
      end
      total++; if (flag_reg !== m_flag || ovfl_sticky !== m_sticky || ovfl_count !== 2'(m_count)) begin
        bad++; $display("FAIL rnd_arch cyc=%0d got %b/%b/%0d exp %b/%b/%0d",
                        c, flag_reg, ovfl_sticky, ovfl_count, m_flag, m_sticky, m_count);
      end
    end
    drive(1'b0, 4'h0, 1'b0, 2'b00);
    clr_sticky = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single_add();
    test_overflow_sub();
    test_backpressure();
    test_logic_after_ovfl();
    test_sticky_sat();
    test_reset_midstream();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
